// File: rtl/punc_fetch_unit_pkg.sv
// Shared encodings for the PUnC fetch stage: PC-select codes, fetch FSM states,
// the HALT instruction word and condition-code bit positions.
package punc_fetch_unit_pkg;

  typedef enum logic [2:0] {
    PC_HOLD      = 3'd0,
    PC_OFFSET9   = 3'd1,
    PC_OFFSET11  = 3'd2,
    PC_RF_R_DATA = 3'd3
  } pc_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_e;

  localparam logic [15:0] HALT_INSTR = 16'hF025;

  localparam int unsigned CC_N = 2;
  localparam int unsigned CC_Z = 1;
  localparam int unsigned CC_P = 0;

  localparam int unsigned TO_CNT_W = 4;

endpackage

// File: rtl/punc_fetch_unit_pc_next.sv
// Combinational next-PC selection: sign-extended IR offsets, register target,
// increment or hold. All sums wrap modulo 2^MEM_W.
module punc_pc_next
  import punc_fetch_unit_pkg::*;
#(
  parameter int unsigned MEM_W = 16
) (
  input  logic [MEM_W-1:0] pc,
  input  logic [10:0]      ir_off,
  input  logic [2:0]       set_pc,
  input  logic             inc_pc,
  input  logic [MEM_W-1:0] rf_r_data,
  output logic [MEM_W-1:0] pc_next_c
);

  logic [MEM_W-1:0] sext9_c;
  logic [MEM_W-1:0] sext11_c;

  assign sext9_c  = {{(MEM_W-9){ir_off[8]}}, ir_off[8:0]};
  assign sext11_c = {{(MEM_W-11){ir_off[10]}}, ir_off[10:0]};

  // Legal non-hold selects win over inc_pc; codes 4-7 behave like hold.
  always_comb begin
    pc_next_c = pc;
    case (set_pc)
      PC_OFFSET9:   pc_next_c = pc + sext9_c;
      PC_OFFSET11:  pc_next_c = pc + sext11_c;
      PC_RF_R_DATA: pc_next_c = rf_r_data;
      default:      pc_next_c = inc_pc ? pc + MEM_W'(1) : pc;
    endcase
  end

endmodule

// File: rtl/punc_fetch_unit.sv
// PUnC PC/IR/condition-code stage with a req/ack instruction fetch FSM.
// Optional PUNC_FETCH_TIMEOUT_EN adds a WAIT timeout that injects HALT and sets fetch_err.
module punc_fetch_unit
  import punc_fetch_unit_pkg::*;
#(
  parameter int unsigned     MEM_W    = 16,
  parameter logic [MEM_W-1:0] RESET_PC = 16'h0000
`ifdef PUNC_FETCH_TIMEOUT_EN
  ,
  parameter int unsigned     TIMEOUT  = 15
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_ir,
  input  logic             inc_pc,
  input  logic [2:0]       set_pc,
  input  logic [MEM_W-1:0] rf_r_data,
  input  logic             rf_w_en,
  input  logic [MEM_W-1:0] rf_w_data,
  output logic             mem_req,
  output logic [MEM_W-1:0] mem_addr,
  input  logic [MEM_W-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic [MEM_W-1:0] opcode,
  output logic [2:0]       condCode,
  output logic [MEM_W-1:0] pc,
`ifdef PUNC_FETCH_TIMEOUT_EN
  output logic             fetch_err,
`endif
  output logic             fetch_busy,
  output logic             ir_valid
);

  fetch_state_e     state_q, state_d;
  logic [MEM_W-1:0] pc_next_c;
  logic [MEM_W-1:0] mem_addr_d, opcode_d;
  logic             mem_req_d, fetch_busy_d, ir_valid_d;
  logic [2:0]       cc_d;
`ifdef PUNC_FETCH_TIMEOUT_EN
  logic [TO_CNT_W-1:0] cnt_q, cnt_d;
  logic                fetch_err_d;
`endif

  punc_pc_next #(.MEM_W(MEM_W)) u_pc_next (
    .pc        (pc),
    .ir_off    (opcode[10:0]),
    .set_pc    (set_pc),
    .inc_pc    (inc_pc),
    .rf_r_data (rf_r_data),
    .pc_next_c (pc_next_c)
  );

  // Fetch FSM next state plus next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req;
    mem_addr_d   = mem_addr;
    opcode_d     = opcode;
    fetch_busy_d = fetch_busy;
    ir_valid_d   = 1'b0;
    cc_d         = condCode;
`ifdef PUNC_FETCH_TIMEOUT_EN
    cnt_d        = cnt_q;
    fetch_err_d  = fetch_err;
`endif

    case (state_q)
      ST_IDLE: begin
        if (load_ir) begin
          mem_addr_d   = pc;
          mem_req_d    = 1'b1;
          fetch_busy_d = 1'b1;
          state_d      = ST_WAIT;
`ifdef PUNC_FETCH_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          opcode_d     = mem_rdata;
          ir_valid_d   = 1'b1;
          mem_req_d    = 1'b0;
          fetch_busy_d = 1'b0;
          state_d      = ST_IDLE;
        end
`ifdef PUNC_FETCH_TIMEOUT_EN
        else if (cnt_q == TO_CNT_W'(TIMEOUT - 1)) begin
          opcode_d     = MEM_W'(HALT_INSTR);
          ir_valid_d   = 1'b1;
          mem_req_d    = 1'b0;
          fetch_busy_d = 1'b0;
          fetch_err_d  = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q + TO_CNT_W'(1);
        end
`endif
      end
    endcase

    // One-hot N/Z/P from the value being written back.
    if (rf_w_en) begin
      cc_d = '0;
      if (rf_w_data[MEM_W-1])   cc_d[CC_N] = 1'b1;
      else if (rf_w_data == '0) cc_d[CC_Z] = 1'b1;
      else                      cc_d[CC_P] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc         <= RESET_PC;
      opcode     <= '0;
      condCode   <= 3'b010;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      fetch_busy <= 1'b0;
      ir_valid   <= 1'b0;
`ifdef PUNC_FETCH_TIMEOUT_EN
      cnt_q      <= '0;
      fetch_err  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc         <= pc_next_c;
      opcode     <= opcode_d;
      condCode   <= cc_d;
      mem_req    <= mem_req_d;
      mem_addr   <= mem_addr_d;
      fetch_busy <= fetch_busy_d;
      ir_valid   <= ir_valid_d;
`ifdef PUNC_FETCH_TIMEOUT_EN
      cnt_q      <= cnt_d;
      fetch_err  <= fetch_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_punc_fetch_unit.sv
// Directed self-checking bench for punc_fetch_unit; expected IR words go through a
// scoreboard queue and are popped when ir_valid pulses.
module tb_punc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, load_ir, inc_pc, rf_w_en, mem_ack;
  logic [2:0]  set_pc;
  logic [15:0] rf_r_data, rf_w_data, mem_rdata;
  logic        mem_req, fetch_busy, ir_valid;
  logic [15:0] mem_addr, opcode, pc;
  logic [2:0]  condCode;
`ifdef PUNC_FETCH_TIMEOUT_EN
  logic        fetch_err;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  punc_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .load_ir    (load_ir),
    .inc_pc     (inc_pc),
    .set_pc     (set_pc),
    .rf_r_data  (rf_r_data),
    .rf_w_en    (rf_w_en),
    .rf_w_data  (rf_w_data),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .opcode     (opcode),
    .condCode   (condCode),
    .pc         (pc),
`ifdef PUNC_FETCH_TIMEOUT_EN
    .fetch_err  (fetch_err),
`endif
    .fetch_busy (fetch_busy),
    .ir_valid   (ir_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bounded wait for ir_valid, then pop the scoreboard and compare the IR.
  task automatic await_ir(input int max_cycles, output int waited);
    waited = 0;
    while (ir_valid !== 1'b1 && waited < max_cycles) begin
      step();
      waited++;
    end
    check("ir_valid_seen", 16'(ir_valid), 16'h1);
    if (ir_valid === 1'b1 && exp_q.size() > 0)
      check("opcode_sb", opcode, exp_q.pop_front());
  endtask

  task automatic fetch_min(input logic [15:0] word);
    int w;
    load_ir = 1'b1;
    step();
    load_ir   = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = word;
    exp_q.push_back(word);
    step();
    mem_ack = 1'b0;
    await_ir(5, w);
    check("min_latency", 16'(w), 16'd0);
    step();
  endtask

  initial begin
    int busy_cycles;
    int w;
    logic addr_ok;

    rst = 1'b1; load_ir = 1'b0; inc_pc = 1'b0; set_pc = 3'd0;
    rf_r_data = '0; rf_w_en = 1'b0; rf_w_data = '0; mem_rdata = '0; mem_ack = 1'b0;
    step();
    step();
    check("rst_pc", pc, 16'h0000);
    check("rst_opcode", opcode, 16'h0000);
    check("rst_cc", 16'(condCode), 16'h0002);
    check("rst_mem_req", 16'(mem_req), 16'h0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_busy", 16'(fetch_busy), 16'h0);
    check("rst_ir_valid", 16'(ir_valid), 16'h0);
    rst = 1'b0;

    // Fetch at pc 0, ack on the 4th WAIT cycle; pc advances meanwhile.
    load_ir = 1'b1;
    step();
    load_ir = 1'b0;
    busy_cycles = 0;
    addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (fetch_busy === 1'b1) busy_cycles++;
      if (mem_addr !== 16'h0000 || mem_req !== 1'b1) addr_ok = 1'b0;
      inc_pc = 1'b1;
      if (i == 3) begin
        mem_ack   = 1'b1;
        mem_rdata = 16'h1261;
        exp_q.push_back(16'h1261);
      end
      step();
    end
    mem_ack = 1'b0;
    inc_pc  = 1'b0;
    check("wait_addr_stable", 16'(addr_ok), 16'h1);
    check("busy_cycles", 16'(busy_cycles), 16'd4);
    check("req_dropped", 16'(mem_req), 16'h0);
    check("busy_dropped", 16'(fetch_busy), 16'h0);
    check("pc_inc_during_wait", pc, 16'h0004);
    await_ir(5, w);
    check("ack_latency", 16'(w), 16'd0);
    step();
    check("ir_valid_pulse", 16'(ir_valid), 16'h0);

    // Branch offsets against the current IR and pc.
    fetch_min(16'h0FFE);
    set_pc = 3'd3; rf_r_data = 16'h3001; step();
    set_pc = 3'd1; step();
    check("pc_off9", pc, 16'h2FFF);
    set_pc = 3'd3; step();
    set_pc = 3'd1; inc_pc = 1'b1; step();
    check("pc_off9_over_inc", pc, 16'h2FFF);
    set_pc = 3'd0; inc_pc = 1'b0;
    fetch_min(16'h0400);
    set_pc = 3'd3; rf_r_data = 16'h3001; step();
    set_pc = 3'd2; step();
    check("pc_off11", pc, 16'h2C01);

    // Wrap, register target and illegal select.
    set_pc = 3'd3; rf_r_data = 16'hFFFF; step();
    check("pc_rf_ffff", pc, 16'hFFFF);
    set_pc = 3'd0; inc_pc = 1'b1; step();
    check("pc_wrap", pc, 16'h0000);
    inc_pc = 1'b0; set_pc = 3'd3; rf_r_data = 16'h4000; step();
    check("pc_rf_4000", pc, 16'h4000);
    set_pc = 3'd5; step();
    check("pc_sel5_hold", pc, 16'h4000);
    set_pc = 3'd0;

    // Condition codes.
    rf_w_en = 1'b1; rf_w_data = 16'h8000; step();
    check("cc_neg", 16'(condCode), 16'h0004);
    rf_w_data = 16'h0000; step();
    check("cc_zero", 16'(condCode), 16'h0002);
    rf_w_data = 16'h0001; step();
    check("cc_pos", 16'(condCode), 16'h0001);
    rf_w_en = 1'b0; rf_w_data = 16'h8000; step();
    check("cc_hold", 16'(condCode), 16'h0001);

    // Repeated load_ir in WAIT, then reset mid-fetch and a late ack.
    load_ir = 1'b1; step();
    check("fetch2_req", 16'(mem_req), 16'h1);
    check("fetch2_addr", mem_addr, 16'h4000);
    inc_pc = 1'b1; step();
    check("fetch2_addr_latched", mem_addr, 16'h4000);
    check("fetch2_busy", 16'(fetch_busy), 16'h1);
    load_ir = 1'b0; inc_pc = 1'b0; rst = 1'b1; step();
    rst = 1'b0;
    check("rst2_pc", pc, 16'h0000);
    check("rst2_req", 16'(mem_req), 16'h0);
    check("rst2_busy", 16'(fetch_busy), 16'h0);
    check("rst2_opcode", opcode, 16'h0000);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF; step();
    mem_ack = 1'b0;
    check("late_ack_opcode", opcode, 16'h0000);
    check("late_ack_ir_valid", 16'(ir_valid), 16'h0);
    check("late_ack_req", 16'(mem_req), 16'h0);

`ifdef PUNC_FETCH_TIMEOUT_EN
    // No ack: HALT injected after 15 WAIT cycles, sticky error until reset.
    check("err_clear", 16'(fetch_err), 16'h0);
    load_ir = 1'b1; step();
    load_ir = 1'b0;
    exp_q.push_back(16'hF025);
    await_ir(40, w);
    check("timeout_cycles", 16'(w), 16'd15);
    check("timeout_err", 16'(fetch_err), 16'h1);
    check("timeout_req", 16'(mem_req), 16'h0);
    step(); step();
    check("err_sticky", 16'(fetch_err), 16'h1);
    check("timeout_pulse", 16'(ir_valid), 16'h0);
    rst = 1'b1; step();
    rst = 1'b0;
    check("err_rst", 16'(fetch_err), 16'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/punc_fetch_unit.md
Name: punc_fetch_unit

Overview:
PC/IR/condition-code stage of the PUnC LC3 datapath, directly downstream of the control unit. It consumes load_ir, inc_pc and set_pc, and produces the instruction word (opcode) and condCode that the control unit decodes. Instruction fetch runs over a req/ack memory handshake, so instruction memory may take multiple cycles. fetch_busy is exported for a future control-side stall.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
MEM_W, 16, address/data width (fixed at 16 for LC3; all arithmetic modulo 2^16)
TIMEOUT, 15, max cycles waiting for mem_ack (used only with optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
load_ir  in  1  start instruction fetch at current PC
inc_pc  in  1  PC <= PC+1
set_pc  in  3  PC source: 0 hold, 1 PC+sext(IR[8:0]), 2 PC+sext(IR[10:0]), 3 rf_r_data; 4-7 treated as hold
rf_r_data  in  16  register-file read port 0 data (JMP/JSRR target)
rf_w_en  in  1  register-file write strobe (cond-code update)
rf_w_data  in  16  register-file write data
mem_req  out  1  instruction read request
mem_addr  out  16  instruction read address
mem_rdata  in  16  instruction read data, valid with mem_ack
mem_ack  in  1  read complete
opcode  out  16  instruction register
condCode  out  3  {N,Z,P}
pc  out  16  current PC (to control-driven ALU/address muxes)
fetch_busy  out  1  fetch outstanding
ir_valid  out  1  one-cycle pulse: IR just loaded

Behaviour:
- Interface decided: one clock clk; reset rst is synchronous and active-high.
- Reset values: pc=RESET_PC, opcode=0, condCode=3'b010, mem_req=0, mem_addr=0, fetch_busy=0, ir_valid=0; FSM to IDLE. Reset mid-fetch aborts the request; a late mem_ack is ignored.
- FSM states:
  - IDLE: load_ir=1 -> mem_addr<=pc (latched), mem_req<=1, fetch_busy<=1, go WAIT.
  - WAIT: mem_req held high, mem_addr stable. On mem_ack -> opcode<=mem_rdata, ir_valid<=1 next cycle, mem_req<=0, fetch_busy<=0, go IDLE. mem_ack in the same cycle the request is raised is not possible; ack is sampled only in WAIT.
- Minimum latency: load_ir at cycle t, mem_ack at t+1 -> opcode updated at t+2 edge, ir_valid high during t+2.
- load_ir while in WAIT: ignored (no second request, no error).
- PC update, evaluated every cycle independently of the FSM:
  - Nonzero legal set_pc has priority over inc_pc.
  - Offsets use the current opcode and current pc (the already-incremented PC).
  - Sign-extension to 16 bits; sums wrap modulo 2^16 (0xFFFF+1 = 0x0000).
- mem_addr is latched at request time, so PC changes during WAIT do not affect the outstanding fetch.
- Cond codes: on rf_w_en, condCode <= N if rf_w_data[15], Z if rf_w_data==0, else P. Exactly one bit is ever set.

Optional Feature:
PUNC_FETCH_TIMEOUT_EN:
- Defined:
  - A 4-bit counter runs in WAIT.
  - When it reaches TIMEOUT without mem_ack: opcode<=16'hF025 (HALT), ir_valid pulses, FSM returns to IDLE, and sticky output fetch_err (1 bit, reset 0) sets.
  - fetch_err clears only on rst.
- Undefined: fetch_err port and counter are absent; WAIT lasts indefinitely.

Decomposition:
- Shared Defines additions:
  - PC-select encodings PC_HOLD/PC_OFFSET9/PC_OFFSET11/PC_RF_R_DATA (values 0-3).
  - Fetch FSM state localparams.
  - HALT_INSTR 16'hF025.
  - CC_N/CC_Z/CC_P bit indices.
- One natural sub-module: punc_pc_next (combinational next-PC mux plus sign-extend adders); FSM and registers stay in the top.

Test Plan:
- Reset, then load_ir with pc=0x0000; memory acks after 3 cycles with 0x1261 -> mem_addr=0x0000 throughout WAIT, opcode=0x1261, ir_valid 1-cycle pulse, fetch_busy high exactly 4 cycles.
- opcode=0x0FFE (BR, offset9=-2), pc=0x3001, set_pc=1 -> pc=0x2FFF; with inc_pc=1 in the same cycle -> still 0x2FFF.
- pc=0xFFFF, inc_pc=1 -> pc=0x0000; set_pc=3, rf_r_data=0x4000 -> pc=0x4000; set_pc=5 -> pc unchanged.
- rf_w_en with data 0x8000/0x0000/0x0001 on consecutive cycles -> condCode 100, 010, 001.
- Second load_ir during WAIT plus rst asserted mid-WAIT -> no extra request; after rst: pc=RESET_PC, mem_req=0, late ack ignored, opcode=0.
- With PUNC_FETCH_TIMEOUT_EN: no ack for 15 cycles -> opcode=0xF025, ir_valid pulses, fetch_err=1 until rst.
